scalar_wb_sequencer: RTL and testbench
======================================

Name: scalar_wb_sequencer

Overview:
Write-back sequencer that produces the single per-cycle write into a warp's scalar register file. It merges two result sources and issues one registered write per cycle:
- ALU results: fixed latency, always accepted.
- LSU results: variable latency, valid/ready handshake, buffered in a small FIFO.

It also keeps a per-register busy scoreboard so the warp scheduler can stall on RAW/WAW hazards against writes still in flight.

Parameters:
DATA_WIDTH, 32, result data width
FIFO_DEPTH, 4, LSU result FIFO entries (power of 2, >=2)
NUM_REGS, 32, scalar registers tracked by the scoreboard (index width 5)

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous: drop queued LSU results, clear scoreboard
issue_valid  input  1  instruction issued that will write rd
issue_rd  input  5  destination of issued instruction
alu_valid  input  1  ALU result present this cycle
alu_rd  input  5  ALU destination
alu_data  input  DATA_WIDTH  ALU result
lsu_valid  input  1  LSU result offered
lsu_ready  output  1  FIFO can accept; equals !full
lsu_rd  input  5  LSU destination
lsu_data  input  DATA_WIDTH  LSU result
chk_rs1, chk_rs2, chk_rd  input  5 each  operands of the candidate instruction
hazard  output  1  combinational: candidate touches a busy register
busy_mask  output  NUM_REGS  registered scoreboard
wb_valid  output  1  registered write strobe to the register file
wb_rd  output  5  registered write index
wb_data  output  DATA_WIDTH  registered write data

Behaviour:
- Reset (reset_n=0, async): FIFO empty, busy_mask=0, wb_valid=0, wb_rd=0, wb_data=0. lsu_ready reads 1 once reset is released. Reset asserted mid-operation discards all queued results.
- Write-back latency is 1 cycle: a source selected in cycle N appears on wb_* in cycle N+1, with wb_valid high for exactly one cycle per write.
- Arbitration, per cycle:
  - If alu_valid and alu_rd!=0, the ALU result is selected. The ALU is never back-pressured.
  - Otherwise, if the FIFO is non-empty, the head is popped and selected.
  - Otherwise wb_valid=0 next cycle.
- LSU handshake:
  - A push occurs when lsu_valid && lsu_ready.
  - lsu_ready = !full. Even if a pop happens the same cycle, no push is accepted while full.
  - A push and a pop in the same cycle when neither full nor empty leaves the count unchanged.
  - Head ordering is strict FIFO; pointers wrap modulo FIFO_DEPTH.
  - lsu_rd==0: the handshake completes (lsu_ready honoured) but the entry is not stored.
- r0 is never written: alu_rd==0 and LSU rd==0 produce no wb_valid.
- Scoreboard:
  - issue_valid with issue_rd!=0 sets busy[issue_rd] next cycle.
  - A write selected in cycle N clears busy[rd] at the same edge that raises wb_valid.
  - Same rd set and cleared in the same cycle: set wins, because the new producer is outstanding.
  - busy[0] is always 0.
- hazard = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd], with index 0 ignored. Only registered state is used; there is no bypass.
- flush:
  - Next cycle: FIFO empty, busy_mask=0, wb_valid=0.
  - alu_valid, lsu_valid and issue_valid in the flush cycle are ignored, and lsu_ready is forced 0 during flush.

Optional Feature:
SCALAR_WB_STATS_EN:
- When defined: adds outputs stat_lsu_blocked (16-bit) and stat_fifo_full (16-bit).
  - stat_lsu_blocked increments each cycle the FIFO is non-empty while the ALU wins arbitration.
  - stat_fifo_full increments each cycle lsu_valid && !lsu_ready.
  - Both counters saturate at 0xFFFF and clear on reset_n or flush.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
1. Reset, then alu_valid, rd=5, data=0xDEADBEEF -> next cycle wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF; the following cycle wb_valid=0.
2. issue rd=7; 3 cycles later LSU returns rd=7, data=0x11 -> busy_mask[7]=1 and hazard=1 for chk_rs1=7 until wb fires; busy clears on the wb_valid edge.
3. Push 4 LSU results (rd=1..4) while alu_valid is held 4 cycles -> lsu_ready=0 after the 4th push; once ALU stops, wb_rd sequence is 1,2,3,4 on consecutive cycles.
4. Same-cycle alu_valid rd=9 and LSU head rd=10 -> rd=9 written first, rd=10 the next cycle; with SCALAR_WB_STATS_EN, stat_lsu_blocked=1.
5. alu_rd=0 and lsu_rd=0 with data 0xFF -> no wb_valid; lsu_ready stays 1; busy_mask unchanged.
6. FIFO holding 3 entries plus busy bits {2,3}, assert flush one cycle -> next cycle FIFO empty, busy_mask=0, no wb_valid. Separately, pull reset_n low mid-stream -> outputs are 0 immediately (async).

Source files
------------

// File: rtl/scalar_wb_sequencer.sv
// Scalar register-file write-back sequencer: ALU/LSU merge, LSU result FIFO, busy scoreboard.
// Optional statistics counters are enabled with `define SCALAR_WB_STATS_EN.
module scalar_wb_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_rd,
  input  logic                  alu_valid,
  input  logic [4:0]            alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [4:0]            lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic [4:0]            chk_rs1,
  input  logic [4:0]            chk_rs2,
  input  logic [4:0]            chk_rd,
  output logic                  hazard,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data
`ifdef SCALAR_WB_STATS_EN
  ,
  output logic [15:0]           stat_lsu_blocked,
  output logic [15:0]           stat_fifo_full
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]            fifo_rd_mem   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full, empty;
  logic                  push, pop, alu_sel;

  logic                  sel_valid_p0;
  logic [4:0]            sel_rd_p0;
  logic [DATA_WIDTH-1:0] sel_data_p0;
  logic [NUM_REGS-1:0]   busy_next;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign lsu_ready = !full && !flush;

  // p0: arbitration and scoreboard update
  always_comb begin
    alu_sel      = alu_valid && (alu_rd != 5'd0) && !flush;
    pop          = !alu_sel && !empty && !flush;
    // rd==0 completes the handshake but is never stored, so every FIFO entry is a real write
    push         = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
    sel_valid_p0 = alu_sel || pop;
    sel_rd_p0    = alu_sel ? alu_rd : fifo_rd_mem[rd_ptr];
    sel_data_p0  = alu_sel ? alu_data : fifo_data_mem[rd_ptr];

    busy_next = busy_mask;
    if (sel_valid_p0)
      busy_next[sel_rd_p0] = 1'b0;
    // a newly issued producer outranks a retiring write to the same register
    if (issue_valid && (issue_rd != 5'd0))
      busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
    if (flush)
      busy_next = '0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_mem[wr_ptr]   <= lsu_rd;
      fifo_data_mem[wr_ptr] <= lsu_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // p1: registered write port and scoreboard
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      busy_mask <= '0;
    end else begin
      wb_valid  <= sel_valid_p0;
      busy_mask <= busy_next;
      if (sel_valid_p0) begin
        wb_rd   <= sel_rd_p0;
        wb_data <= sel_data_p0;
      end
    end
  end

  assign hazard = ((chk_rs1 != 5'd0) && busy_mask[chk_rs1]) ||
                  ((chk_rs2 != 5'd0) && busy_mask[chk_rs2]) ||
                  ((chk_rd  != 5'd0) && busy_mask[chk_rd]);

`ifdef SCALAR_WB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_lsu_blocked <= '0;
      stat_fifo_full   <= '0;
    end else if (flush) begin
      stat_lsu_blocked <= '0;
      stat_fifo_full   <= '0;
    end else begin
      if (alu_sel && !empty)
        stat_lsu_blocked <= sat_inc16(stat_lsu_blocked);
      if (lsu_valid && !lsu_ready)
        stat_fifo_full <= sat_inc16(stat_fifo_full);
    end
  end
`endif

endmodule

// File: tb/tb_scalar_wb_sequencer.sv
// Self-checking bench for scalar_wb_sequencer: scoreboard of expected write-backs plus per-scenario checks.
module tb_scalar_wb_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, flush, issue_valid, alu_valid, lsu_valid, lsu_ready;
  logic [4:0]  issue_rd, alu_rd, lsu_rd, chk_rs1, chk_rs2, chk_rd, wb_rd;
  logic [31:0] alu_data, lsu_data, wb_data, busy_mask;
  logic        hazard, wb_valid;
`ifdef SCALAR_WB_STATS_EN
  logic [15:0] stat_lsu_blocked, stat_fifo_full;
`endif

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } exp_t;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  scalar_wb_sequencer #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .NUM_REGS(32)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .hazard(hazard), .busy_mask(busy_mask),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
`ifdef SCALAR_WB_STATS_EN
    , .stat_lsu_blocked(stat_lsu_blocked), .stat_fifo_full(stat_fifo_full)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && wb_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got rd=%0d data=%08h, required no write", wb_rd, wb_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (wb_rd !== e.rd || wb_data !== e.data) begin
          errors++;
          $display("FAIL sb_write: got rd=%0d data=%08h, required rd=%0d data=%08h",
                   wb_rd, wb_data, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    flush = 0; issue_valid = 0; issue_rd = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset_n = 0;
    #12;
    checks++;
    if (wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0 || busy_mask !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b rd=%0d data=%08h busy=%08h, required all 0",
               wb_valid, wb_rd, wb_data, busy_mask);
    end
    tick();
    reset_n = 1;
    tick();
    checks++;
    if (lsu_ready !== 1'b1 || hazard !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got ready=%b hazard=%b, required 1 0", lsu_ready, hazard);
    end
  endtask

  task automatic test_alu;
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    exp_q.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
    tick();
    alu_valid = 0;
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL alu_wb: got v=%b rd=%0d data=%08h, required 1 5 deadbeef", wb_valid, wb_rd, wb_data);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL alu_one_shot: got wb_valid=%b, required 0", wb_valid);
    end
  endtask

  task automatic test_scoreboard;
    issue_valid = 1; issue_rd = 7; chk_rs1 = 7;
    tick();
    issue_valid = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busy_mask[7] !== 1'b1 || hazard !== 1'b1) begin
        errors++;
        $display("FAIL sb_busy_wait%0d: got busy7=%b hazard=%b, required 1 1", i, busy_mask[7], hazard);
      end
      tick();
    end
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h11;
    exp_q.push_back('{rd: 5'd7, data: 32'h11});
    tick();
    lsu_valid = 0;
    checks++;
    if (busy_mask[7] !== 1'b1 || hazard !== 1'b1 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL sb_busy_queued: got busy7=%b hazard=%b wb=%b, required 1 1 0",
               busy_mask[7], hazard, wb_valid);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b1 || busy_mask[7] !== 1'b0 || hazard !== 1'b0) begin
      errors++;
      $display("FAIL sb_clear: got wb=%b busy7=%b hazard=%b, required 1 0 0",
               wb_valid, busy_mask[7], hazard);
    end
    chk_rs1 = 0;
    tick();
  endtask

  task automatic test_fifo_full;
    logic [15:0] base_blk, base_full;
`ifdef SCALAR_WB_STATS_EN
    base_blk = stat_lsu_blocked; base_full = stat_fifo_full;
`else
    base_blk = 0; base_full = 0;
`endif
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lsu_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_ready_fill%0d: got lsu_ready=%b, required 1", i, lsu_ready);
      end
      alu_valid = 1; alu_rd = 5'(20 + i); alu_data = 32'hA000 + i;
      lsu_valid = 1; lsu_rd = 5'(1 + i); lsu_data = 32'h100 + i;
      exp_q.push_back('{rd: 5'(20 + i), data: 32'hA000 + i});
      tick();
    end
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{rd: 5'(1 + i), data: 32'h100 + i});
    alu_valid = 0; lsu_rd = 31; lsu_data = 32'hBAD;
    checks++;
    if (lsu_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready_low: got lsu_ready=%b, required 0", lsu_ready);
    end
    tick();
    lsu_valid = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wb_valid !== 1'b1 || wb_rd !== 5'(1 + i)) begin
        errors++;
        $display("FAIL full_drain%0d: got v=%b rd=%0d, required 1 %0d", i, wb_valid, wb_rd, 1 + i);
      end
      tick();
    end
    checks++;
    if (wb_valid !== 1'b0 || lsu_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_drained: got wb=%b ready=%b, required 0 1", wb_valid, lsu_ready);
    end
`ifdef SCALAR_WB_STATS_EN
    checks++;
    if (stat_lsu_blocked !== base_blk + 16'd3 || stat_fifo_full !== base_full + 16'd1) begin
      errors++;
      $display("FAIL full_stats: got blk=%0d full=%0d, required %0d %0d",
               stat_lsu_blocked, stat_fifo_full, base_blk + 16'd3, base_full + 16'd1);
    end
`endif
  endtask

  task automatic test_arbitration;
    logic [15:0] base_blk;
    lsu_valid = 1; lsu_rd = 10; lsu_data = 32'hA10;
    tick();
    lsu_valid = 0;
`ifdef SCALAR_WB_STATS_EN
    base_blk = stat_lsu_blocked;
`else
    base_blk = 0;
`endif
    alu_valid = 1; alu_rd = 9; alu_data = 32'h909;
    exp_q.push_back('{rd: 5'd9, data: 32'h909});
    exp_q.push_back('{rd: 5'd10, data: 32'hA10});
    tick();
    alu_valid = 0;
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd9) begin
      errors++;
      $display("FAIL arb_alu_first: got v=%b rd=%0d, required 1 9", wb_valid, wb_rd);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd10) begin
      errors++;
      $display("FAIL arb_lsu_next: got v=%b rd=%0d, required 1 10", wb_valid, wb_rd);
    end
`ifdef SCALAR_WB_STATS_EN
    checks++;
    if (stat_lsu_blocked !== base_blk + 16'd1) begin
      errors++;
      $display("FAIL arb_stat: got %0d, required %0d", stat_lsu_blocked, base_blk + 16'd1);
    end
`endif
    tick();
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lsu_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready%0d: got lsu_ready=%b, required 1", i, lsu_ready);
      end
      lsu_valid = 1; lsu_rd = 5'(16 + i); lsu_data = 32'hB000 + i;
      exp_q.push_back('{rd: 5'(16 + i), data: 32'hB000 + i});
      tick();
      if (i > 0) begin
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'(15 + i)) begin
          errors++;
          $display("FAIL b2b_wb%0d: got v=%b rd=%0d, required 1 %0d", i, wb_valid, wb_rd, 15 + i);
        end
      end
    end
    lsu_valid = 0;
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd19) begin
      errors++;
      $display("FAIL b2b_last: got v=%b rd=%0d, required 1 19", wb_valid, wb_rd);
    end
    tick();
  endtask

  task automatic test_zero_rd;
    logic [31:0] busy_before;
    busy_before = busy_mask;
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFF;
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hFF;
    checks++;
    if (lsu_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_ready: got lsu_ready=%b, required 1", lsu_ready);
    end
    tick();
    alu_valid = 0; lsu_valid = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (wb_valid !== 1'b0 || lsu_ready !== 1'b1 || busy_mask !== busy_before) begin
        errors++;
        $display("FAIL zero_nowrite%0d: got wb=%b ready=%b busy=%08h, required 0 1 %08h",
                 i, wb_valid, lsu_ready, busy_mask, busy_before);
      end
      tick();
    end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) begin
      issue_valid = (i < 2); issue_rd = 5'(2 + i);
      alu_valid = 1; alu_rd = 25; alu_data = 32'hC000 + i;
      lsu_valid = 1; lsu_rd = 5'(11 + i); lsu_data = 32'hD000 + i;
      exp_q.push_back('{rd: 5'd25, data: 32'hC000 + i});
      tick();
    end
    checks++;
    if (busy_mask !== 32'h0000_000C) begin
      errors++;
      $display("FAIL flush_pre_busy: got %08h, required 0000000c", busy_mask);
    end
    flush = 1;
    issue_valid = 1; issue_rd = 4;
    alu_valid = 1; alu_rd = 26; alu_data = 32'hEEEE;
    lsu_valid = 1; lsu_rd = 14; lsu_data = 32'hEEEE;
    #1;
    checks++;
    if (lsu_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got lsu_ready=%b, required 0", lsu_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (busy_mask !== 32'd0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: got busy=%08h wb=%b, required 0 0", busy_mask, wb_valid);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b0 || lsu_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_fifo_empty: got wb=%b ready=%b, required 0 1", wb_valid, lsu_ready);
    end
  endtask

  task automatic test_async_reset;
    alu_valid = 1; alu_rd = 6; alu_data = 32'h6666;
    lsu_valid = 1; lsu_rd = 15; lsu_data = 32'hF00D;
    issue_valid = 1; issue_rd = 8;
    exp_q.push_back('{rd: 5'd6, data: 32'h6666});
    tick();
    idle_inputs();
    checks++;
    if (busy_mask[8] !== 1'b1 || wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got busy8=%b wb=%b, required 1 1", busy_mask[8], wb_valid);
    end
    @(negedge clk);
    #1;
    reset_n = 0;
    #1;
    checks++;
    if (wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0 || busy_mask !== 32'd0) begin
      errors++;
      $display("FAIL areset_immediate: got v=%b rd=%0d data=%08h busy=%08h, required all 0",
               wb_valid, wb_rd, wb_data, busy_mask);
    end
    tick();
    reset_n = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (wb_valid !== 1'b0 || lsu_ready !== 1'b1) begin
        errors++;
        $display("FAIL areset_discard%0d: got wb=%b ready=%b, required 0 1", i, wb_valid, lsu_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_scoreboard();
    test_fifo_full();
    test_arbitration();
    test_back_to_back();
    test_zero_rd();
    test_flush();
    test_async_reset();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
